period_scan_ctrl: RTL and testbench

- Round-robin scheduler sharing one millisecond-resolution period-measurement engine among N_CH asynchronous input signals.
- Sequencing per channel: select, arm on first rising edge, count ce1ms ticks to the next rising edge, store, advance.
- Channels with no edges are bounded by a timeout.
- Sits between the raw signal inputs and the display/readout logic; results are held in a per-channel register bank.

---
 rtl/period_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_period_scan_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_scan_ctrl.sv
// period_scan_ctrl: round-robin scheduler that shares one ms-resolution
// period-measurement engine among N_CH asynchronous inputs. For each channel
// in turn it arms on the first rising edge, counts ce1ms ticks up to the next
// rising edge, stores the result in a per-channel bank and moves on. Channels
// without edges are abandoned after TIMEOUT_MS ticks in ARM or in MEAS.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | parked, waiting for en
// LOAD  | new channel selected; edge history primed from its current level
// ARM   | waiting for the first rising edge, counting ticks toward timeout
// MEAS  | counting ticks until the second rising edge or timeout
// STORE | result written to the bank and presented on res_*
// NEXT  | advance cur_ch, then continue scanning or park
module period_scan_ctrl #(
    parameter  int N_CH       = 4,
    parameter  int W          = 16,
    parameter  int TIMEOUT_MS = 2000,
    localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce1ms,
    input  logic            en,
    input  logic [N_CH-1:0] sig,
    input  logic [CW-1:0]   rd_sel,
    output logic [W-1:0]    rd_period,
    output logic            rd_timeout,
    output logic            res_valid,
    output logic [CW-1:0]   res_ch,
    output logic [W-1:0]    res_period,
    output logic            res_timeout,
    output logic [CW-1:0]   cur_ch,
    output logic            busy
);

    // The bank is sized to the full select range so rd_sel can index it
    // directly; entries at or above N_CH are never written and read as 0.
    localparam int NB = 1 << CW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        MEAS  = 3'd3,
        STORE = 3'd4,
        NEXT  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N_CH-1:0] sync_a;
    logic [N_CH-1:0] sync_b;
    logic            s_cur;
    logic            prev;
    logic            rise;

    logic [W-1:0]    cnt;
    logic            tick_to;

    logic [W-1:0]    pend_period;
    logic            pend_timeout;

    logic [W-1:0]    bank_period [NB];
    logic [NB-1:0]   bank_to;

    // Edge detection works on the synchronized level of the owned channel only.
    assign s_cur   = sync_b[cur_ch];
    assign rise    = s_cur & ~prev;

    // The TIMEOUT_MS-th tick seen in the current phase ends it.
    assign tick_to = ce1ms && (cnt == W'(TIMEOUT_MS - 1));

    assign busy       = (state != IDLE);
    assign rd_period  = bank_period[rd_sel];
    assign rd_timeout = bank_to[rd_sel];

    // Two-stage synchronizer for every input bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= sig;
            sync_b <= sync_a;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a rising edge always takes priority over a timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = ARM;
            end
            ARM: begin
                if (rise) begin
                    state_nxt = MEAS;
                end else if (tick_to) begin
                    state_nxt = STORE;
                end
            end
            MEAS: begin
                if (rise || tick_to) begin
                    state_nxt = STORE;
                end
            end
            STORE: begin
                state_nxt = NEXT;
            end
            NEXT: begin
                state_nxt = en ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Measurement datapath: edge history, tick counter and pending result.
    // prev follows the owned channel every clock, so in LOAD it picks up the
    // newly selected channel's level and a held-high input gives no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev         <= 1'b0;
            cnt          <= '0;
            pend_period  <= '0;
            pend_timeout <= 1'b0;
            cur_ch       <= '0;
        end else begin
            prev <= s_cur;
            case (state)
                LOAD: begin
                    cnt <= '0;
                end
                ARM: begin
                    if (rise) begin
                        // a tick coincident with the first edge is not counted
                        cnt <= '0;
                    end else begin
                        if (ce1ms) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (tick_to) begin
                            pend_period  <= '0;
                            pend_timeout <= 1'b1;
                        end
                    end
                end
                MEAS: begin
                    if (ce1ms) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (rise) begin
                        // a tick coincident with the second edge is counted
                        pend_period  <= cnt + W'(ce1ms);
                        pend_timeout <= 1'b0;
                    end else if (tick_to) begin
                        pend_period  <= '0;
                        pend_timeout <= 1'b1;
                    end
                end
                NEXT: begin
                    cur_ch <= (cur_ch == CW'(N_CH - 1)) ? '0 : cur_ch + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result bank and result outputs, written only from STORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                bank_period[i] <= '0;
            end
            bank_to     <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_period  <= '0;
            res_timeout <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (state == STORE) begin
                bank_period[cur_ch] <= pend_period;
                bank_to[cur_ch]     <= pend_timeout;
                res_valid           <= 1'b1;
                res_ch              <= cur_ch;
                res_period          <= pend_period;
                res_timeout         <= pend_timeout;
            end
        end
    end

endmodule

// File: tb/tb_period_scan_ctrl.sv
// tb_period_scan_ctrl: each segment prepares a full input waveform, derives
// the expected results from it with a window-based reference model, then
// plays the waveform while a monitor pops and compares every res_valid.
module tb_period_scan_ctrl;

    localparam int N_CH = 4;
    localparam int W    = 16;
    localparam int T    = 2000;
    localparam int CW   = $clog2(N_CH);
    localparam int MAXC = 13000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ce1ms = 1'b0;
    logic            en = 1'b0;
    logic [N_CH-1:0] sig = '0;
    logic [CW-1:0]   rd_sel = '0;
    logic [W-1:0]    rd_period;
    logic            rd_timeout;
    logic            res_valid;
    logic [CW-1:0]   res_ch;
    logic [W-1:0]    res_period;
    logic            res_timeout;
    logic [CW-1:0]   cur_ch;
    logic            busy;

    period_scan_ctrl #(.N_CH(N_CH), .W(W), .TIMEOUT_MS(T)) dut (
        .clk(clk), .rst(rst), .ce1ms(ce1ms), .en(en), .sig(sig),
        .rd_sel(rd_sel), .rd_period(rd_period), .rd_timeout(rd_timeout),
        .res_valid(res_valid), .res_ch(res_ch), .res_period(res_period),
        .res_timeout(res_timeout), .cur_ch(cur_ch), .busy(busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        int ch;
        int period;
        bit to;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   tot_pushed = 0;
    int   tot_popped = 0;

    bit [N_CH-1:0] sig_a [MAXC];
    bit            ce_a  [MAXC];
    bit            en_a  [MAXC];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Cycle k is the k-th clock edge after reset release; the engine sees
    // input sig_a[k-2] at edge k because of the two-stage synchronizer.
    function automatic bit s_at(int c, int k);
        if (k < 2) return 1'b0;
        return sig_a[k-2][c];
    endfunction

    function automatic int first_rise(int c, int from, int n);
        for (int k = from; k < n; k++)
            if (s_at(c, k) && !s_at(c, k - 1)) return k;
        return -1;
    endfunction

    function automatic int nth_tick(int from, int cnt, int n);
        int seen = 0;
        for (int k = from; k < n; k++)
            if (ce_a[k]) begin
                seen++;
                if (seen == cnt) return k;
            end
        return -1;
    endfunction

    function automatic int ticks_in(int a, int b);
        int s = 0;
        for (int k = a; k <= b; k++) s += int'(ce_a[k]);
        return s;
    endfunction

    function automatic int first_en(int from, int n);
        for (int k = from; k < n; k++)
            if (en_a[k]) return k;
        return -1;
    endfunction

    // Result = ticks in (first edge, second edge]; edge beats timeout.
    // Only results whose STORE edge precedes the closing reset are expected.
    task automatic run_model(input int n);
        int ch, L, e1, e2, ta, tm, fin, per, k;
        bit to;
        res_t r;
        ch = 0;
        k = first_en(0, n);
        if (k < 0) return;
        L = k + 1;
        while (L < n) begin
            e1 = first_rise(ch, L + 1, n);
            ta = nth_tick(L + 1, T, n);
            if (e1 >= 0 && (ta < 0 || e1 <= ta)) begin
                e2 = first_rise(ch, e1 + 1, n);
                tm = nth_tick(e1 + 1, T, n);
                if (e2 >= 0 && (tm < 0 || e2 <= tm)) begin
                    fin = e2; per = ticks_in(e1 + 1, e2); to = 1'b0;
                end else if (tm >= 0) begin
                    fin = tm; per = 0; to = 1'b1;
                end else return;
            end else if (ta >= 0) begin
                fin = ta; per = 0; to = 1'b1;
            end else return;
            if (fin + 1 >= n) return;
            r.ch = ch; r.period = per; r.to = to;
            exp_q.push_back(r);
            tot_pushed++;
            ch = (ch + 1) % N_CH;
            if (fin + 2 >= n) return;
            if (en_a[fin + 2]) begin
                L = fin + 3;
            end else begin
                k = first_en(fin + 3, n);
                if (k < 0) return;
                L = k + 1;
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (res_valid) begin
            tot_popped++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got ch %0d period %0d timeout %0d, expected no result",
                         res_ch, res_period, res_timeout);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sb_ch", int'(res_ch), e.ch);
                check("sb_period", int'(res_period), e.period);
                check("sb_timeout", int'(res_timeout), int'(e.to));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit sq(int k, int half);
        return ((k / half) % 2) == 1;
    endfunction

    task automatic clear_seg(input int n);
        for (int k = 0; k < n; k++) begin
            sig_a[k] = '0;
            ce_a[k]  = 1'b0;
            en_a[k]  = 1'b0;
        end
    endtask

    task automatic play(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst   = 1'b0;
            sig   = sig_a[k];
            ce1ms = ce_a[k];
            en    = en_a[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input int c, input int per, input int to);
        rd_sel = CW'(c);
        #1;
        check("rd_period", int'(rd_period), per);
        check("rd_timeout", int'(rd_timeout), to);
    endtask

    task automatic reset_checks();
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_ch", int'(res_ch), 0);
        check("rst_res_period", int'(res_period), 0);
        check("rst_res_timeout", int'(res_timeout), 0);
        check("rst_cur_ch", int'(cur_ch), 0);
        check("rst_busy", int'(busy), 0);
        for (int c = 0; c < N_CH; c++) begin
            rd_sel = CW'(c);
            #1;
            check("rst_bank_period", int'(rd_period), 0);
            check("rst_bank_timeout", int'(rd_timeout), 0);
        end
    endtask

    task automatic end_seg();
        @(negedge clk);
        rst = 1'b1; ce1ms = 1'b0; en = 1'b0; sig = '0;
        @(posedge clk);
        #1;
        check("sb_leftover", exp_q.size(), 0);
        check("result_count", tot_popped, tot_pushed);
        exp_q.delete();
        reset_checks();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int lvl, hold;
        bit e;

        repeat (2) @(posedge clk);
        #1;
        reset_checks();

        // ch0 25 ms square wave, others silent -> three ARM timeouts
        n = 12400;
        clear_seg(n);
        for (int k = 0; k < n; k++) begin
            en_a[k] = 1'b1;
            ce_a[k] = (k % 2) == 0;
            sig_a[k][0] = sq(k, 25);
        end
        run_model(n);
        play(n);
        rd_chk(0, 25, 0); rd_chk(1, 0, 1); rd_chk(2, 0, 1); rd_chk(3, 0, 1);
        end_seg();

        // all channels toggling at 10/20/30/40 ms, then en drops
        n = 1200;
        clear_seg(n);
        for (int k = 0; k < n; k++) begin
            en_a[k] = k < 600;
            ce_a[k] = (k % 2) == 0;
            for (int c = 0; c < N_CH; c++) sig_a[k][c] = sq(k, 10 * (c + 1));
        end
        run_model(n);
        play(n);
        check("scan_busy", int'(busy), 0);
        rd_chk(0, 10, 0); rd_chk(1, 20, 0); rd_chk(2, 30, 0); rd_chk(3, 40, 0);
        end_seg();

        // single edge on ch2 then silence -> MEAS timeout; reset lands in ch3 ARM
        n = 5000;
        clear_seg(n);
        for (int k = 0; k < n; k++) begin
            en_a[k] = 1'b1;
            ce_a[k] = (k % 2) == 0;
            sig_a[k][0] = sq(k, 20);
            sig_a[k][1] = sq(k, 20);
            sig_a[k][2] = k >= 600;
        end
        run_model(n);
        play(n);
        rd_chk(0, 20, 0); rd_chk(1, 20, 0); rd_chk(2, 0, 1);
        end_seg();

        // tick coincident with first edge; second edge on / one clk after 5th tick
        for (int off = 0; off < 2; off++) begin
            n = 150;
            clear_seg(n);
            en_a[0] = 1'b1;
            for (int i = 0; i < 6; i++) ce_a[22 + 10 * i] = 1'b1;
            for (int k = 0; k < n; k++)
                sig_a[k][0] = (k >= 20 && k < 40) || (k >= 70 + off);
            run_model(n);
            play(n);
            check("coinc_cur_ch", int'(cur_ch), 1);
            check("coinc_busy", int'(busy), 0);
            rd_chk(0, 5, 0);
            end_seg();
        end

        // ch1 already high at selection: only the genuine 0->1 starts the window
        n = 700;
        clear_seg(n);
        for (int k = 0; k < n; k++) begin
            en_a[k] = k < 100;
            ce_a[k] = (k % 2) == 0;
            sig_a[k][0] = sq(k, 20);
            sig_a[k][1] = (k < 200) || (k >= 300 && k < 400) || (k >= 450);
        end
        run_model(n);
        play(n);
        check("held_cur_ch", int'(cur_ch), 2);
        check("held_busy", int'(busy), 0);
        rd_chk(1, 75, 0);
        end_seg();

        // reset during ch1 MEAS: partial result discarded
        n = 600;
        clear_seg(n);
        for (int k = 0; k < n; k++) begin
            en_a[k] = 1'b1;
            ce_a[k] = (k % 2) == 0;
            sig_a[k][0] = sq(k, 20);
            sig_a[k][1] = k >= 300;
        end
        run_model(n);
        play(n);
        check("midmeas_busy", int'(busy), 1);
        check("midmeas_cur_ch", int'(cur_ch), 1);
        end_seg();

        // en dropped during ch0 MEAS: ch0 completes, then park with cur_ch=1
        n = 400;
        clear_seg(n);
        for (int k = 0; k < n; k++) begin
            en_a[k] = k < 150;
            ce_a[k] = (k % 2) == 0;
            sig_a[k][0] = sq(k, 50);
        end
        run_model(n);
        play(n);
        check("park_busy", int'(busy), 0);
        check("park_cur_ch", int'(cur_ch), 1);
        rd_chk(0, 50, 0);
        end_seg();

        // randomized waveforms, tick pattern and enable
        for (int r = 0; r < 3; r++) begin
            n = 3000;
            clear_seg(n);
            for (int c = 0; c < N_CH; c++) begin
                lvl = 0;
                hold = int'($urandom_range(1, 60));
                for (int k = 0; k < n; k++) begin
                    sig_a[k][c] = lvl[0];
                    hold--;
                    if (hold == 0) begin
                        lvl = 1 - lvl;
                        hold = int'($urandom_range(1, 60));
                    end
                end
            end
            e = 1'b1;
            for (int k = 0; k < n; k++) begin
                ce_a[k] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 199) == 0) e = ~e;
                en_a[k] = e;
            end
            run_model(n);
            play(n);
            end_seg();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
